// File: rtl/nx_rbus_master.sv
// Host-side initiator for the register bus ring: one outstanding read/write, strobe out, ack/err_ack back.
// Optional response timeout is enabled by defining NX_RBUS_MASTER_TIMEOUT_EN.
module nx_rbus_master #(
    parameter int unsigned                  N_RBUS_ADDR_BITS = 16,
    parameter int unsigned                  N_RBUS_DATA_BITS = 32,
    parameter int unsigned                  TIMEOUT_CYCLES   = 1024,
    parameter logic [N_RBUS_DATA_BITS-1:0]  TIMEOUT_DATA     = N_RBUS_DATA_BITS'(32'hDEAD_C0DE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        host_req_i,
    input  logic                        host_wr_i,
    input  logic [N_RBUS_ADDR_BITS-1:0] host_addr_i,
    input  logic [N_RBUS_DATA_BITS-1:0] host_wr_data_i,
    output logic                        host_gnt_o,
    output logic                        host_done_o,
    output logic [N_RBUS_DATA_BITS-1:0] host_rd_data_o,
    output logic                        host_err_o,
    output logic                        host_timeout_o,
    output logic                        busy_o,
    output logic [N_RBUS_ADDR_BITS-1:0] rbus_addr_o,
    output logic                        rbus_wr_strb_o,
    output logic [N_RBUS_DATA_BITS-1:0] rbus_wr_data_o,
    output logic                        rbus_rd_strb_o,
    input  logic [N_RBUS_DATA_BITS-1:0] rbus_rd_data_i,
    input  logic                        rbus_ack_i,
    input  logic                        rbus_err_ack_i,
    output logic [7:0]                  stray_ack_cnt_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                  state_q;
    logic [1:0]                  state_d;
    logic                        wr_q;
    logic [N_RBUS_ADDR_BITS-1:0] addr_q;
    logic [N_RBUS_DATA_BITS-1:0] wr_data_q;
    logic [N_RBUS_DATA_BITS-1:0] rd_data_q;
    logic                        err_q;
    logic                        timeout_q;
    logic [7:0]                  stray_q;
    logic                        resp;
    logic                        expire;

    assign resp = rbus_ack_i | rbus_err_ack_i;

`ifdef NX_RBUS_MASTER_TIMEOUT_EN
    localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0]                wait_cnt_q;

    // Counter is 0 in the first WAIT cycle, so CNT_LAST marks the TIMEOUT_CYCLES-th cycle after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            wait_cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign expire = (state_q == ST_WAIT) && (wait_cnt_q == CNT_LAST);
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign expire     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (host_req_i) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (resp || expire) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && host_req_i) begin
                wr_q      <= host_wr_i;
                addr_q    <= host_addr_i;
                wr_data_q <= host_wr_data_i;
            end
        end
    end

    // A response in the expiry cycle takes priority over the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            if (resp) begin
                rd_data_q <= wr_q ? '0 : rbus_rd_data_i;
                err_q     <= rbus_err_ack_i;
                timeout_q <= 1'b0;
            end else if (expire) begin
                rd_data_q <= TIMEOUT_DATA;
                err_q     <= 1'b0;
                timeout_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stray_q <= '0;
        end else if (resp && state_q != ST_WAIT && stray_q != 8'hFF) begin
            stray_q <= stray_q + 8'd1;
        end
    end

    assign host_gnt_o      = (state_q == ST_ISSUE);
    assign host_done_o     = (state_q == ST_DONE);
    assign busy_o          = (state_q != ST_IDLE);
    assign rbus_wr_strb_o  = (state_q == ST_ISSUE) &&  wr_q;
    assign rbus_rd_strb_o  = (state_q == ST_ISSUE) && !wr_q;
    assign rbus_addr_o     = addr_q;
    assign rbus_wr_data_o  = wr_data_q;
    assign host_rd_data_o  = rd_data_q;
    assign host_err_o      = err_q;
    assign host_timeout_o  = timeout_q;
    assign stray_ack_cnt_o = stray_q;

endmodule

// File: tb/tb_nx_rbus_master.sv
// Directed self-checking bench for nx_rbus_master; completion status is checked through a scoreboard queue.
module tb_nx_rbus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_req_i;
    logic        host_wr_i;
    logic [15:0] host_addr_i;
    logic [31:0] host_wr_data_i;
    logic        host_gnt_o;
    logic        host_done_o;
    logic [31:0] host_rd_data_o;
    logic        host_err_o;
    logic        host_timeout_o;
    logic        busy_o;
    logic [15:0] rbus_addr_o;
    logic        rbus_wr_strb_o;
    logic [31:0] rbus_wr_data_o;
    logic        rbus_rd_strb_o;
    logic [31:0] rbus_rd_data_i;
    logic        rbus_ack_i;
    logic        rbus_err_ack_i;
    logic [7:0]  stray_ack_cnt_o;

    typedef struct packed {
        logic [31:0] rd_data;
        logic        err;
        logic        timeout;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    nx_rbus_master #(
        .N_RBUS_ADDR_BITS (16),
        .N_RBUS_DATA_BITS (32),
        .TIMEOUT_CYCLES   (16),
        .TIMEOUT_DATA     (32'hDEAD_C0DE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .host_req_i      (host_req_i),
        .host_wr_i       (host_wr_i),
        .host_addr_i     (host_addr_i),
        .host_wr_data_i  (host_wr_data_i),
        .host_gnt_o      (host_gnt_o),
        .host_done_o     (host_done_o),
        .host_rd_data_o  (host_rd_data_o),
        .host_err_o      (host_err_o),
        .host_timeout_o  (host_timeout_o),
        .busy_o          (busy_o),
        .rbus_addr_o     (rbus_addr_o),
        .rbus_wr_strb_o  (rbus_wr_strb_o),
        .rbus_wr_data_o  (rbus_wr_data_o),
        .rbus_rd_strb_o  (rbus_rd_strb_o),
        .rbus_rd_data_i  (rbus_rd_data_i),
        .rbus_ack_i      (rbus_ack_i),
        .rbus_err_ack_i  (rbus_err_ack_i),
        .stray_ack_cnt_o (stray_ack_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] rd, input logic err, input logic to);
        exp_t e;
        e.rd_data = rd;
        e.err     = err;
        e.timeout = to;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input string tag);
        exp_t e;
        check({tag, ":sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, ":rd_data"}, host_rd_data_o, e.rd_data);
            check({tag, ":err"},     32'(host_err_o), 32'(e.err));
            check({tag, ":timeout"}, 32'(host_timeout_o), 32'(e.timeout));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ":busy"},  32'(busy_o), 32'd0);
        check({tag, ":gnt_done"}, 32'({host_gnt_o, host_done_o}), 32'd0);
        check({tag, ":strobes"},  32'({rbus_wr_strb_o, rbus_rd_strb_o}), 32'd0);
        check({tag, ":addr"},     32'(rbus_addr_o), 32'd0);
        check({tag, ":wr_data"},  rbus_wr_data_o, 32'd0);
        check({tag, ":status"},   32'({host_rd_data_o != 32'd0, host_err_o, host_timeout_o}), 32'd0);
        check({tag, ":stray"},    32'(stray_ack_cnt_o), 32'd0);
    endtask

    // Drive one request, respond `delay` cycles after the strobe cycle (0 = never), expect done at exp_lat.
    task automatic run_txn(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [31:0] wdata, input int unsigned delay,
                           input logic ack, input logic eack, input logic [31:0] rdata,
                           input int unsigned exp_lat, input logic [31:0] e_rd,
                           input logic e_err, input logic e_to);
        bit          got;
        int unsigned lat;
        host_req_i     = 1'b1;
        host_wr_i      = wr;
        host_addr_i    = addr;
        host_wr_data_i = wdata;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (host_gnt_o) got = 1'b1;
        end
        check({tag, ":gnt"}, 32'(got), 32'd1);
        if (!got) begin
            host_req_i = 1'b0;
            return;
        end
        check({tag, ":wr_strb"}, 32'(rbus_wr_strb_o), 32'(wr));
        check({tag, ":rd_strb"}, 32'(rbus_rd_strb_o), 32'(!wr));
        check({tag, ":addr"},    32'(rbus_addr_o), 32'(addr));
        if (wr) check({tag, ":wr_data"}, rbus_wr_data_o, wdata);
        push_exp(e_rd, e_err, e_to);
        host_req_i = 1'b0;
        lat = 0;
        for (int unsigned i = 1; i <= exp_lat + 4 && lat == 0; i++) begin
            @(negedge clk);
            rbus_ack_i     = 1'b0;
            rbus_err_ack_i = 1'b0;
            rbus_rd_data_i = 32'hFFFF_FFFF;
            if (i == 1) check({tag, ":strobe_1cyc"}, 32'({rbus_wr_strb_o, rbus_rd_strb_o}), 32'd0);
            if (host_done_o) begin
                lat = i;
            end else if (i == delay) begin
                rbus_ack_i     = ack;
                rbus_err_ack_i = eack;
                rbus_rd_data_i = rdata;
            end
        end
        rbus_ack_i     = 1'b0;
        rbus_err_ack_i = 1'b0;
        check({tag, ":latency"}, lat, exp_lat);
        if (lat != 0) sb_pop(tag);
        else void'(exp_q.pop_front());
    endtask

    initial begin
        int grants;
        int last_done;
        int ack_at;
        int no_done;
        bit got;

        rst_n          = 1'b0;
        host_req_i     = 1'b0;
        host_wr_i      = 1'b0;
        host_addr_i    = '0;
        host_wr_data_i = '0;
        rbus_rd_data_i = '0;
        rbus_ack_i     = 1'b0;
        rbus_err_ack_i = 1'b0;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn("wr", 1'b1, 16'h0123, 32'hA5A5_0001, 3, 1'b1, 1'b0, 32'hFFFF_FFFF,
                4, 32'h0, 1'b0, 1'b0);
        check("wr:wr_data_hold", rbus_wr_data_o, 32'hA5A5_0001);
        run_txn("rd", 1'b0, 16'h0400, 32'h0, 2, 1'b1, 1'b0, 32'h1234_5678,
                3, 32'h1234_5678, 1'b0, 1'b0);
        check("rd:busy_in_done", 32'(busy_o), 32'd1);
        run_txn("rd_both", 1'b0, 16'h0401, 32'h0, 2, 1'b1, 1'b1, 32'h0000_BEEF,
                3, 32'h0000_BEEF, 1'b1, 1'b0);
        run_txn("rd_err", 1'b0, 16'h0402, 32'h0, 1, 1'b0, 1'b1, 32'h0000_CAFE,
                2, 32'h0000_CAFE, 1'b1, 1'b0);
        @(negedge clk);
        check("status_hold:rd_data", host_rd_data_o, 32'h0000_CAFE);

`ifdef NX_RBUS_MASTER_TIMEOUT_EN
        run_txn("tmo", 1'b0, 16'h0777, 32'h0, 0, 1'b0, 1'b0, 32'h0,
                17, 32'hDEAD_C0DE, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        rbus_ack_i     = 1'b1;
        rbus_rd_data_i = 32'h1111_2222;
        @(negedge clk);
        rbus_ack_i = 1'b0;
        no_done = 0;
        for (int i = 0; i < 3; i++) begin
            if (host_done_o || busy_o) no_done++;
            @(negedge clk);
        end
        check("tmo:late_ack_no_done", no_done, 0);
        check("tmo:stray", 32'(stray_ack_cnt_o), 32'd1);
        check("tmo:status_hold", host_rd_data_o, 32'hDEAD_C0DE);
        check("tmo:timeout_hold", 32'(host_timeout_o), 32'd1);
`else
        run_txn("no_tmo", 1'b0, 16'h0777, 32'h0, 30, 1'b1, 1'b0, 32'h0BAD_F00D,
                31, 32'h0BAD_F00D, 1'b0, 1'b0);
        check("no_tmo:stray", 32'(stray_ack_cnt_o), 32'd0);
`endif

        // Request held high across three transactions; ring acks two cycles after each strobe.
        host_req_i     = 1'b1;
        host_wr_i      = 1'b1;
        host_addr_i    = 16'h0200;
        host_wr_data_i = 32'h0000_0100;
        rbus_rd_data_i = 32'h5555_AAAA;
        grants    = 0;
        last_done = -100;
        ack_at    = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            rbus_ack_i = (c == ack_at);
            if (host_done_o) begin
                last_done = c;
                sb_pop("b2b");
            end
            if (host_gnt_o) begin
                grants++;
                if (grants > 1) check("b2b:gap", 32'(c - last_done), 32'd2);
                check("b2b:wr_data", rbus_wr_data_o, host_wr_data_i);
                push_exp(32'h0, 1'b0, 1'b0);
                ack_at = c + 2;
                host_wr_data_i = host_wr_data_i + 32'd1;
                if (grants == 3) host_req_i = 1'b0;
            end
        end
        rbus_ack_i = 1'b0;
        check("b2b:grants", grants, 3);

        host_req_i  = 1'b1;
        host_wr_i   = 1'b0;
        host_addr_i = 16'h0555;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (host_gnt_o) got = 1'b1;
        end
        check("rst:gnt", 32'(got), 32'd1);
        host_req_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst:in_wait", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rbus_ack_i     = 1'b1;
        rbus_rd_data_i = 32'h7777_7777;
        @(negedge clk);
        rbus_ack_i = 1'b0;
        no_done = 0;
        for (int i = 0; i < 3; i++) begin
            if (host_done_o || busy_o) no_done++;
            @(negedge clk);
        end
        check("rst:no_done", no_done, 0);
        check("rst:stray", 32'(stray_ack_cnt_o), 32'd1);
        check("rst:rd_data", host_rd_data_o, 32'd0);

        rbus_err_ack_i = 1'b1;
        repeat (300) @(negedge clk);
        rbus_err_ack_i = 1'b0;
        @(negedge clk);
        check("stray:saturate", 32'(stray_ack_cnt_o), 32'd255);
        check("stray:idle", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
